// File: rtl/xbus_pkg.sv
// X-bus controller shared definitions: bundle layout, client ids, arbitration modes, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package xbus_pkg;

  // Default sizing of the controller
  localparam int XBUS_N_CLIENTS = 2;
  localparam int XBUS_CFG_W     = 256;
  localparam int XBUS_P         = 8;

  // Client indices
  localparam int CLIENT_CONV = 0;
  localparam int CLIENT_POOL = 1;

  // Arbitration modes
  localparam int ARB_FIXED = 0;  // lowest pending index wins
  localparam int ARB_RR    = 1;  // search starts at rr_ptr

  // Parameter bundle layout: bit offset (_OFS) and width (_W) of each field.
  // Bits above XZ_OFS+XZ_W are reserved and carried through untouched.
  localparam int XPHM_ADDR_OFS        = 0;    localparam int XPHM_ADDR_W        = 32;
  localparam int XPHM_LEN_MINUS_1_OFS = 32;   localparam int XPHM_LEN_MINUS_1_W = 16;
  localparam int X_ADDR_OFS           = 48;   localparam int X_ADDR_W           = 32;
  localparam int INC2_MINUS_1_OFS     = 80;   localparam int INC2_MINUS_1_W     = 16;
  localparam int INW_OFS              = 96;   localparam int INW_W              = 16;
  localparam int INH2_OFS             = 112;  localparam int INH2_W             = 16;
  localparam int INW2_OFS             = 128;  localparam int INW2_W             = 16;
  localparam int KH_MINUS_1_OFS       = 144;  localparam int KH_MINUS_1_W       = 4;
  localparam int KW_MINUS_1_OFS       = 148;  localparam int KW_MINUS_1_W       = 4;
  localparam int STRIDE_H_OFS         = 152;  localparam int STRIDE_H_W         = 4;
  localparam int STRIDE_W_OFS         = 156;  localparam int STRIDE_W_W         = 4;
  localparam int PAD_L_OFS            = 160;  localparam int PAD_L_W            = 4;
  localparam int PAD_U_OFS            = 164;  localparam int PAD_U_W            = 4;
  localparam int IFM_HEIGHT_OFS       = 168;  localparam int IFM_HEIGHT_W       = 16;
  localparam int ROW_BOUND_OFS        = 184;  localparam int ROW_BOUND_W        = 16;
  localparam int COL_BOUND_OFS        = 200;  localparam int COL_BOUND_W        = 16;
  localparam int XZ_OFS               = 216;  localparam int XZ_W               = 8;

  // Controller FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

endpackage

// File: rtl/xbus_rr_pick.sv
// Combinational picker: one-hot grant + index among pending clients, fixed priority or round-robin.
// Latency: combinational, zero cycles.
// Backpressure: none; grant_vld low when nothing is pending.
// Ports: pend (pending flags), rr_ptr (round-robin start index, ignored in fixed mode),
//        grant (one-hot), grant_idx (binary index of grant), grant_vld (any grant).
module xbus_rr_pick import xbus_pkg::*; #(
  parameter int N        = 2,
  parameter int IW       = 1,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic [N-1:0]  pend,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  int             base;
  int             idx;
  logic [IW-1:0]  sel;

  // Walk the clients starting at base, wrapping once; the first pending one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    base      = (ARB_MODE == ARB_RR) ? int'(rr_ptr) : 0;
    idx       = 0;
    sel       = '0;
    for (int off = 0; off < N; off++) begin
      idx = base + off;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (!grant_vld && pend[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbus_ctrl_arb.sv
// X-bus front-end: buffers one request per client, arbitrates, issues one job at a time, tracks completion.
// Latency: request cycle to start_pulse is 2 cycles; job_done to next start_pulse is 2 cycles.
// Backpressure: one pending slot per client; a request into a full slot is dropped and flagged sticky.
// Ports: req_start/req_cfg in, req_accept/req_done out per client; start_pulse/cfg/owner/busy to the
//        datapath, job_done back from it; cache_full -> registered stall; sticky error flags.
module xbus_ctrl_arb import xbus_pkg::*; #(
  parameter int N_CLIENTS = XBUS_N_CLIENTS,
  parameter int CFG_W     = XBUS_CFG_W,
  parameter int P         = XBUS_P,
  parameter int ARB_MODE  = ARB_FIXED,
  localparam int IW       = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CLIENTS-1:0]       req_start,
  input  logic [N_CLIENTS*CFG_W-1:0] req_cfg,
  output logic [N_CLIENTS-1:0]       req_accept,
  output logic [N_CLIENTS-1:0]       req_done,
  output logic                       start_pulse,
  output logic [CFG_W-1:0]           cfg,
  output logic [IW-1:0]              owner,
  output logic                       busy,
  input  logic                       job_done,
  input  logic [P-1:0]               cache_full,
  output logic                       stall,
  output logic [N_CLIENTS-1:0]       err_overflow,
  output logic                       err_spurious
);

  state_t               state, state_nxt;
  logic [N_CLIENTS-1:0] pend;
  logic [CFG_W-1:0]     cfg_buf [N_CLIENTS];
  logic [IW-1:0]        rr_ptr;

  logic [N_CLIENTS-1:0] grant;
  logic [IW-1:0]        grant_idx;
  logic                 grant_vld;
  logic                 grant_take;
  logic [N_CLIENTS-1:0] take;

  xbus_rr_pick #(
    .N        (N_CLIENTS),
    .IW       (IW),
    .ARB_MODE (ARB_MODE)
  ) u_pick (
    .pend      (pend),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt   = state;
    grant_take  = 1'b0;
    start_pulse = 1'b0;
    busy        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          grant_take = 1'b1;
          state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_pulse = 1'b1;
        busy        = 1'b1;
        state_nxt   = ST_BUSY;
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (job_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    take = grant & {N_CLIENTS{grant_take}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Request slots. A grant frees the slot in the same cycle, so a new
  // request arriving alongside the grant is captured rather than dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend         <= '0;
      req_accept   <= '0;
      err_overflow <= '0;
      for (int i = 0; i < N_CLIENTS; i++) cfg_buf[i] <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        req_accept[i] <= 1'b0;
        if (req_start[i] && (!pend[i] || take[i])) begin
          pend[i]       <= 1'b1;
          cfg_buf[i]    <= req_cfg[i*CFG_W +: CFG_W];
          req_accept[i] <= 1'b1;
        end else if (take[i]) begin
          pend[i] <= 1'b0;
        end
        if (req_start[i] && pend[i] && !take[i]) err_overflow[i] <= 1'b1;
      end
    end
  end

  // Issued job, round-robin pointer and completion reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg          <= '0;
      owner        <= '0;
      rr_ptr       <= '0;
      req_done     <= '0;
      err_spurious <= 1'b0;
      stall        <= 1'b0;
    end else begin
      if (grant_take) begin
        cfg    <= cfg_buf[grant_idx];
        owner  <= grant_idx;
        rr_ptr <= (grant_idx == IW'(N_CLIENTS - 1)) ? '0 : grant_idx + IW'(1);
      end
      req_done <= '0;
      if (state == ST_BUSY && job_done) req_done[owner] <= 1'b1;
      if (job_done && state != ST_BUSY) err_spurious <= 1'b1;
      stall <= |cache_full;
    end
  end

endmodule

// File: tb/tb_xbus_ctrl_arb.sv
module tb_xbus_ctrl_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Fixed-priority instance, 2 clients, 256-bit bundles
  logic [1:0]   req_start = '0;
  logic [511:0] req_cfg = '0;
  logic [1:0]   req_accept, req_done, err_overflow;
  logic         start_pulse, busy, stall, err_spurious;
  logic [255:0] cfg;
  logic [0:0]   owner;
  logic         job_done = 1'b0;
  logic [7:0]   cache_full = '0;

  xbus_ctrl_arb #(.N_CLIENTS(2), .CFG_W(256), .P(8), .ARB_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_start(req_start), .req_cfg(req_cfg),
    .req_accept(req_accept), .req_done(req_done), .start_pulse(start_pulse),
    .cfg(cfg), .owner(owner), .busy(busy), .job_done(job_done),
    .cache_full(cache_full), .stall(stall), .err_overflow(err_overflow),
    .err_spurious(err_spurious)
  );

  // Round-robin instance, 4 clients, 16-bit bundles
  logic [3:0]  r_req_start = '0;
  logic [63:0] r_req_cfg = '0;
  logic [3:0]  r_req_accept, r_req_done, r_err_overflow;
  logic        r_start_pulse, r_busy, r_stall, r_err_spurious;
  logic [15:0] r_cfg;
  logic [1:0]  r_owner;
  logic        r_job_done = 1'b0;
  logic [7:0]  r_cache_full = '0;

  xbus_ctrl_arb #(.N_CLIENTS(4), .CFG_W(16), .P(8), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_start(r_req_start), .req_cfg(r_req_cfg),
    .req_accept(r_req_accept), .req_done(r_req_done), .start_pulse(r_start_pulse),
    .cfg(r_cfg), .owner(r_owner), .busy(r_busy), .job_done(r_job_done),
    .cache_full(r_cache_full), .stall(r_stall), .err_overflow(r_err_overflow),
    .err_spurious(r_err_spurious)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [255:0] CFG_A = 256'hA0A0_0001_1234_5678;
  localparam logic [255:0] CFG_B = 256'hB0B0_0002_0000_00FF;
  localparam logic [255:0] CFG_C = {8'hCC, 240'h0, 8'h5A};
  localparam logic [255:0] CFG_D = 256'hD0D0_0004;
  localparam logic [255:0] CFG_E = 256'hE0E0_0005;
  localparam logic [255:0] CFG_F = 256'hF0F0_0006;
  localparam logic [255:0] CFG_G = 256'h6060_0007;

  int exp_own [5] = '{0, 1, 2, 3, 0};
  logic [15:0] exp_rcfg [5] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hB000};

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", start_pulse, 0);
    chk("rst_accept", req_accept, 0);
    chk("rst_cfg", cfg, 0);
    chk("rst_errs", {err_overflow, err_spurious, stall}, 0);
    rst_n = 1'b1;
    tick();

    // ---------------- single pool request ----------------
    req_start = 2'b10; req_cfg[511:256] = CFG_A;
    tick();
    req_start = 2'b00; req_cfg = '0;
    chk("t1_accept", req_accept, 2'b10);
    chk("t1_no_start_yet", start_pulse, 0);
    tick();
    chk("t1_start", start_pulse, 1);
    chk("t1_cfg", cfg, CFG_A);
    chk("t1_owner", owner, 1);
    chk("t1_accept_once", req_accept, 0);
    tick();
    chk("t1_start_1cyc", start_pulse, 0);
    chk("t1_busy", busy, 1);
    repeat (8) tick();
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    chk("t1_done", req_done, 2'b10);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_done_1cyc", req_done, 0);

    // ---------------- simultaneous conv+pool, fixed priority ----------------
    req_start = 2'b11; req_cfg = {CFG_C, CFG_B};
    tick();
    req_start = 2'b00; req_cfg = '0;
    chk("t2_accept", req_accept, 2'b11);
    tick();
    chk("t2_start0", start_pulse, 1);
    chk("t2_owner0", owner, 0);
    chk("t2_cfg0", cfg, CFG_B);
    repeat (3) tick();
    chk("t2_cfg0_held", cfg, CFG_B);
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    chk("t2_done0", req_done, 2'b01);
    chk("t2_gap_start", start_pulse, 0);
    tick();
    chk("t2_start1", start_pulse, 1);
    chk("t2_owner1", owner, 1);
    chk("t2_cfg1", cfg, CFG_C);
    tick();
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    chk("t2_done1", req_done, 2'b10);
    tick();

    // ---------------- overflow + grant/request collision ----------------
    req_start = 2'b10; req_cfg[511:256] = CFG_E;
    tick();
    req_start = 2'b00;
    tick(); tick();
    chk("t3_busy_pool", busy, 1);
    req_start = 2'b01; req_cfg[255:0] = CFG_D;
    tick();
    chk("t3_accept_d", req_accept, 2'b01);
    chk("t3_no_ovf", err_overflow, 0);
    req_cfg[255:0] = CFG_F;
    tick();
    req_start = 2'b00;
    chk("t3_no_accept_f", req_accept, 0);
    chk("t3_ovf", err_overflow, 2'b01);
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    chk("t3_done_pool", req_done, 2'b10);
    // new conv request lands in the same cycle the slot is granted
    req_start = 2'b01; req_cfg[255:0] = CFG_G;
    tick();
    req_start = 2'b00;
    chk("t3_accept_g", req_accept, 2'b01);
    chk("t3_start_d", start_pulse, 1);
    chk("t3_cfg_d", cfg, CFG_D);
    chk("t3_owner_d", owner, 0);
    tick();
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    chk("t3_done_d", req_done, 2'b01);
    tick();
    chk("t3_start_g", start_pulse, 1);
    chk("t3_cfg_g", cfg, CFG_G);
    tick();
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    tick();
    chk("t3_idle", busy, 0);

    // ---------------- stall and spurious job_done ----------------
    chk("t4_stall0", stall, 0);
    cache_full = 8'h04;
    #4;
    chk("t4_stall_registered", stall, 0);
    tick();
    cache_full = 8'h00;
    chk("t4_stall1", stall, 1);
    tick();
    chk("t4_stall_clear", stall, 0);
    chk("t4_no_spur", err_spurious, 0);
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    chk("t4_spur", err_spurious, 1);
    chk("t4_spur_no_done", req_done, 0);
    tick();
    chk("t4_spur_sticky", err_spurious, 1);

    // ---------------- reset mid-job ----------------
    req_start = 2'b01; req_cfg[255:0] = CFG_A;
    tick();
    req_start = 2'b00;
    tick(); tick();
    chk("t5_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", busy, 0);
    chk("t5_cfg_rst", cfg, 0);
    chk("t5_errs_rst", {err_overflow, err_spurious, owner}, 0);
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    chk("t5_idle_after", {busy, start_pulse}, 0);
    req_start = 2'b10; req_cfg[511:256] = CFG_B;
    tick();
    req_start = 2'b00;
    chk("t5_accept", req_accept, 2'b10);
    tick();
    chk("t5_start", start_pulse, 1);
    chk("t5_cfg", cfg, CFG_B);
    tick();
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    tick();

    // ---------------- round robin, 4 clients ----------------
    r_req_start = 4'b1111;
    r_req_cfg = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    tick();
    r_req_start = 4'b0000; r_req_cfg = '0;
    chk("rr_accept", r_req_accept, 4'b1111);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_start%0d", i), r_start_pulse, 1);
      chk($sformatf("rr_owner%0d", i), r_owner, exp_own[i]);
      chk($sformatf("rr_cfg%0d", i), r_cfg, exp_rcfg[i]);
      tick();
      if (i == 1) begin
        // conv re-requests while client 1 runs; RR must still serve 2 and 3 first
        r_req_start = 4'b0001; r_req_cfg[15:0] = 16'hB000;
        tick();
        r_req_start = 4'b0000;
      end
      r_job_done = 1'b1;
      tick();
      r_job_done = 1'b0;
      chk($sformatf("rr_done%0d", i), r_req_done, 4'b0001 << exp_own[i]);
      tick();
    end
    chk("rr_idle_end", r_busy, 0);
    chk("rr_no_ovf", r_err_overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
